cs_y_collector: RTL



---
 rtl/cs_y_collector.sv | 114 +++++++++++
 1 files changed

// File: rtl/cs_y_collector.sv
// Collects the CS Y result stream: drops warm-up results, buffers the rest in a FWFT FIFO.
// Optional running min/max statistics are built when CS_STATS_EN is defined.
module cs_y_collector #(
    parameter int DEPTH  = 16,
    parameter int WARMUP = 9
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [9:0]               y_in,
    input  logic                     y_vld,
    output logic [9:0]               out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     ovf,
    input  logic                     clr_ovf,
    output logic [9:0]               y_max,
    output logic [9:0]               y_min
);

    localparam int DATA_W = 10;
    localparam int AW     = $clog2(DEPTH);
    localparam int LW     = AW + 1;
    localparam int WC_W   = (WARMUP > 1) ? $clog2(WARMUP) : 1;
    localparam logic [WC_W-1:0] WC_MAX = WC_W'(WARMUP - 1);
    localparam logic [LW-1:0]   LV_FULL = LW'(DEPTH);

    logic [WC_W-1:0]   r_wcnt;
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [LW-1:0]     r_level;
    logic              r_ovf;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic w_elig;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_drop;

    // Warm-up counter holds at its terminal value once the CS window is full.
    function automatic logic [WC_W-1:0] wcnt_next(input logic [WC_W-1:0] cnt);
        return (cnt == WC_MAX) ? cnt : cnt + WC_W'(1);
    endfunction

    assign w_elig    = y_vld && (r_wcnt == WC_MAX);
    assign w_full    = (r_level == LV_FULL);
    assign out_valid = (r_level != '0);
    assign w_pop     = out_valid && out_ready;
    assign w_push    = w_elig && (!w_full || w_pop);
    assign w_drop    = w_elig && w_full && !w_pop;

    assign out_data = r_mem[r_rd_ptr];
    assign level    = r_level;
    assign ovf      = r_ovf;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wcnt   <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (y_vld)
                r_wcnt <= wcnt_next(r_wcnt);
            if (w_push)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
            // A drop in the same cycle as a clear leaves the flag set.
            if (w_drop)
                r_ovf <= 1'b1;
            else if (clr_ovf)
                r_ovf <= 1'b0;
        end
    end

    // Storage carries data only, so it is not reset.
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= y_in;
    end

`ifdef CS_STATS_EN
    logic [DATA_W-1:0] r_y_max;
    logic [DATA_W-1:0] r_y_min;

    // Reset values (0 / all-ones) make the first push load y_in into both.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_y_max <= '0;
            r_y_min <= '1;
        end else if (w_push) begin
            if (y_in > r_y_max)
                r_y_max <= y_in;
            if (y_in < r_y_min)
                r_y_min <= y_in;
        end
    end

    assign y_max = r_y_max;
    assign y_min = r_y_min;
`else
    assign y_max = 10'd0;
    assign y_min = 10'h3FF;
`endif

endmodule
